pll_seq_ctrl: RTL

Power-up sequencer and dynamic phase-shift controller for the SDRAM PLL (PLLA, 50 MHz in, 100 MHz outputs). Holds the PLL in reset, qualifies LOCK, releases the rest of the design via `sys_ready`, and serialises phase-step requests onto the PLL's PSSEL/PSDIR/PSPULSE pins so the SDRAM clock phase can be calibrated at run time. Runs from the free-running board clock, never from a PLL output.

---
 rtl/pll_seq_ctrl.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/pll_seq_ctrl.sv
// pll_seq_ctrl: power-up sequencer and dynamic phase-shift controller for the
// SDRAM PLL. Holds the PLL in reset, qualifies LOCK, raises sys_ready and
// serialises phase-step requests onto PSSEL/PSDIR/PSPULSE.
// Clocked from the free-running board clock, never from a PLL output.
// Build option: define PLL_SEQ_RELOCK_EN to relock automatically after lock
// loss; otherwise lock loss parks the controller in FAULT until rst.
module pll_seq_ctrl #(
  parameter int unsigned RST_CYCLES   = 16,
  parameter int unsigned LOCK_STABLE  = 1024,
  parameter int unsigned LOCK_TIMEOUT = 65535,
  parameter int unsigned PULSE_WIDTH  = 4,
  parameter int unsigned PH_W         = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pll_lock,
  output logic              pll_reset,
  output logic [2:0]        pll_pssel,
  output logic              pll_psdir,
  output logic              pll_pspulse,
  input  logic              ps_req,
  input  logic [2:0]        ps_ch,
  input  logic              ps_dir,
  output logic              ps_ack,
  output logic              ps_err,
  output logic              ps_busy,
  output logic              sys_ready,
  output logic [3*PH_W-1:0] phase_pos,
  output logic [7:0]        relock_cnt
);

  localparam int unsigned RW  = $clog2(RST_CYCLES + 1);
  localparam int unsigned PWW = $clog2(PULSE_WIDTH + 1);
  localparam int unsigned CW  = (RW > PWW) ? RW : PWW;
  localparam int unsigned SW  = $clog2(LOCK_STABLE + 1);
  localparam int unsigned TW  = $clog2(LOCK_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_RESET,
    S_WAIT_LOCK,
    S_RUN,
    S_PS_SETUP,
    S_PS_LOW,
    S_PS_HOLD,
    S_FAULT
  } state_t;

  state_t            state_q;
  logic [1:0]        sync_q;
  logic              lock_s;
  logic              lock_lost_c;
  logic [CW-1:0]     cnt_q;
  logic [SW-1:0]     stable_q;
  logic [TW-1:0]     tmo_q;
  logic [1:0]        ch_q;
  logic              psdir_q;
  logic              pll_reset_q;
  logic              pspulse_q;
  logic              ps_ack_q;
  logic              ps_err_q;
  logic              ps_busy_q;
  logic              sys_ready_q;
  logic [PH_W-1:0]   phase_q [3];
  logic [7:0]        relock_q;

  // Two-flop synchroniser for the asynchronous PLL LOCK pin
  always_ff @(posedge clk) begin
    if (rst) sync_q <= 2'b00;
    else     sync_q <= {sync_q[0], pll_lock};
  end

  assign lock_s = sync_q[1];

  // Lock loss only matters once the PLL has been qualified
  assign lock_lost_c = !lock_s && (state_q == S_RUN || state_q == S_PS_SETUP ||
                                   state_q == S_PS_LOW || state_q == S_PS_HOLD);

  // Sequencer FSM with all outputs registered
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_RESET;
      cnt_q       <= '0;
      stable_q    <= '0;
      tmo_q       <= '0;
      ch_q        <= '0;
      psdir_q     <= 1'b0;
      pll_reset_q <= 1'b1;
      pspulse_q   <= 1'b1;
      ps_ack_q    <= 1'b0;
      ps_err_q    <= 1'b0;
      ps_busy_q   <= 1'b1;
      sys_ready_q <= 1'b0;
      phase_q     <= '{default: '0};
      relock_q    <= '0;
    end else begin
      ps_ack_q <= 1'b0;
      ps_err_q <= 1'b0;
      if (lock_lost_c) begin
        // Abort any in-flight step; the pulse pin returns to idle
        if (relock_q != 8'hFF) relock_q <= relock_q + 8'd1;
        phase_q     <= '{default: '0};
        pspulse_q   <= 1'b1;
        sys_ready_q <= 1'b0;
        ps_busy_q   <= 1'b1;
        cnt_q       <= '0;
`ifdef PLL_SEQ_RELOCK_EN
        state_q     <= S_RESET;
        pll_reset_q <= 1'b1;
`else
        state_q     <= S_FAULT;
        pll_reset_q <= 1'b0;
`endif
      end else begin
        case (state_q)
          S_RESET: begin
            phase_q <= '{default: '0};
            if (cnt_q == CW'(RST_CYCLES - 1)) begin
              state_q     <= S_WAIT_LOCK;
              cnt_q       <= '0;
              stable_q    <= '0;
              tmo_q       <= '0;
              pll_reset_q <= 1'b0;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
          S_WAIT_LOCK: begin
            if (lock_s && stable_q == SW'(LOCK_STABLE - 1)) begin
              state_q     <= S_RUN;
              sys_ready_q <= 1'b1;
              ps_busy_q   <= 1'b0;
            end else if (tmo_q == TW'(LOCK_TIMEOUT - 1)) begin
              state_q     <= S_RESET;
              cnt_q       <= '0;
              pll_reset_q <= 1'b1;
            end else begin
              stable_q <= lock_s ? stable_q + SW'(1) : '0;
              tmo_q    <= tmo_q + TW'(1);
            end
          end
          S_RUN: begin
            if (ps_req) begin
              if (ps_ch <= 3'd2) begin
                state_q   <= S_PS_SETUP;
                cnt_q     <= '0;
                ch_q      <= ps_ch[1:0];
                psdir_q   <= ps_dir;
                ps_busy_q <= 1'b1;
              end else begin
                ps_ack_q <= 1'b1;
                ps_err_q <= 1'b1;
              end
            end
          end
          S_PS_SETUP: begin
            if (cnt_q == CW'(PULSE_WIDTH - 1)) begin
              state_q   <= S_PS_LOW;
              cnt_q     <= '0;
              pspulse_q <= 1'b0;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
          S_PS_LOW: begin
            if (cnt_q == CW'(PULSE_WIDTH - 1)) begin
              state_q   <= S_PS_HOLD;
              cnt_q     <= '0;
              pspulse_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
          S_PS_HOLD: begin
            if (cnt_q == CW'(PULSE_WIDTH - 1)) begin
              state_q   <= S_RUN;
              cnt_q     <= '0;
              ps_ack_q  <= 1'b1;
              ps_busy_q <= 1'b0;
              for (int n = 0; n < 3; n++) begin
                if (ch_q == 2'(n))
                  phase_q[n] <= psdir_q ? phase_q[n] + PH_W'(1) : phase_q[n] - PH_W'(1);
              end
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
          S_FAULT: begin
            pll_reset_q <= 1'b0;
          end
          default: begin
            state_q     <= S_RESET;
            cnt_q       <= '0;
            pll_reset_q <= 1'b1;
            ps_busy_q   <= 1'b1;
            sys_ready_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign pll_reset   = pll_reset_q;
  assign pll_pssel   = {1'b0, ch_q};
  assign pll_psdir   = psdir_q;
  assign pll_pspulse = pspulse_q;
  assign ps_ack      = ps_ack_q;
  assign ps_err      = ps_err_q;
  assign ps_busy     = ps_busy_q;
  assign sys_ready   = sys_ready_q;
  assign phase_pos   = {phase_q[2], phase_q[1], phase_q[0]};
  assign relock_cnt  = relock_q;

endmodule
